falafel_lsu_arbiter: RTL
========================

Name: falafel_lsu_arbiter

Overview:
- Shares one LSU request/response channel between N_REQ requesters (allocator, freer, config path).
- Keeps ownership for a whole lock session. A requester whose LOCK op is granted holds the LSU exclusively until its UNLOCK response returns, so free-list walks are atomic.
- Sits between the alloc/free engines and the LSU. At most one LSU transaction is outstanding.

Parameters:
- N_REQ, 2, number of requesters (>=2).
- IDX_W, $clog2(N_REQ), requester index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  N_REQ x $bits(header_req_t)  per-requester LSU request; .val qualifies.
- req_rdy_o  out  N_REQ  per-requester accept; a request is taken when req_i[k].val & req_rdy_o[k].
- rsp_o  out  N_REQ x $bits(header_rsp_t)  per-requester response; .val is a 1-cycle pulse.
- lsu_req_o  out  $bits(header_req_t)  request to the LSU.
- lsu_req_rdy_i  in  1  LSU accepts lsu_req_o when lsu_req_o.val & lsu_req_rdy_i.
- lsu_rsp_i  in  $bits(header_rsp_t)  LSU response; .val is a 1-cycle pulse.
- owner_o  out  IDX_W  current owner index (valid when busy_o).
- locked_o  out  1  a lock session is open.
- busy_o  out  1  state != IDLE or locked_o.
- err_o  out  1  1-cycle protocol-error pulse.

Behaviour:
- Reset values: all req_rdy_o = 0, all rsp_o = 0, lsu_req_o = 0, owner_o = 0, locked_o = 0, busy_o = 0, err_o = 0. Round-robin pointer rr = 0, state = IDLE.
- States:
  - IDLE: accept one request.
  - ISSUE: drive the LSU.
  - WAIT_RSP: wait for the LSU response.
- IDLE, locked_o = 0:
  - Winner = first k with req_i[k].val, searching rr, rr+1, ... mod N_REQ.
  - req_rdy_o[winner] = 1 combinationally; all others 0.
  - On accept: register the request, owner <= winner, go to ISSUE.
- IDLE, locked_o = 1:
  - Only req_rdy_o[owner] may be 1.
  - Other requesters see rdy = 0 regardless of val.
- ISSUE:
  - lsu_req_o = registered request, with .val = 1.
  - Held stable until lsu_req_rdy_i.
  - Then lsu_req_o.val <= 0 and go to WAIT_RSP.
- WAIT_RSP:
  - On lsu_rsp_i.val: rsp_o[owner] = lsu_rsp_i in the same cycle (combinational route); every other rsp_o.val = 0.
  - Next state is IDLE.
  - If the op was LOCK: locked_o <= 1.
  - If the op was UNLOCK: locked_o <= 0 and rr <= owner+1 mod N_REQ.
  - Any other op with locked_o = 0: rr <= owner+1 mod N_REQ.
  - Any other op with locked_o = 1: rr unchanged, lock kept.
- Latency: accept cycle T, lsu_req_o.val at T+1 (min), response forwarded in the cycle it arrives. Minimum back-to-back accept is every 3 cycles.
- All req_rdy_o = 0 in ISSUE and WAIT_RSP.
- err_o pulses for one cycle, and the transaction is still forwarded, when:
  - a LOCK is accepted while locked_o = 1;
  - an UNLOCK is accepted while locked_o = 0.
- lsu_rsp_i.val outside WAIT_RSP: err_o pulses, the response is dropped, no rsp_o.val.
- Simultaneous val from all requesters in IDLE (unlocked): only the rr-priority winner is accepted; others wait with rdy = 0.
- rr wrap: owner = N_REQ-1 → rr = 0.
- Reset asserted mid-transaction or mid-lock: all state is discarded immediately, including the lock. No rsp_o is produced for the aborted transaction.
- lsu_req_o.lsu_op and header bits are passed through unmodified. This block never inspects addresses or sizes.

Test Plan:
- Single request: req_i[0] = LOAD, addr 0x40; lsu_req_rdy_i = 1. Expect lsu_req_o.val at cycle T+1 carrying addr 0x40; lsu_rsp_i size 0x30 at T+4 → rsp_o[0].val = 1 with size 0x30 at T+4, rsp_o[1].val = 0. Then busy_o = 0 and rr = 1.
- Contention: req 0 and req 1 both val in the same cycle after reset. Expect req 0 accepted first, then req 1 accepted in the next IDLE (rr = 1). Then with both val again, req 0 is accepted (fairness).
- Lock session:
  - req 1 issues LOCK, then LOAD, EDIT_SIZE_AND_NEXT_ADDR, UNLOCK.
  - req 0 holds val throughout.
  - Expect req_rdy_o[0] = 0 until the cycle after req 1's UNLOCK response.
  - locked_o = 1 from the LOCK response to the UNLOCK response; owner_o = 1.
- Backpressure: lsu_req_rdy_i = 0 for 5 cycles during ISSUE. Expect lsu_req_o stable with val = 1 for all 6 cycles, and no req_rdy_o asserted.
- Errors:
  - UNLOCK with no lock open → err_o pulse, request still forwarded.
  - Spurious lsu_rsp_i.val in IDLE → err_o pulse, no rsp_o.val.
- Reset during lock: reset while locked_o = 1 and in WAIT_RSP. Expect all outputs at reset values next cycle. Then req 0 LOAD is accepted normally.

Source files
------------

// File: rtl/falafel_lsu_arbiter.sv
// Shares one LSU request/response channel between N_REQ requesters, with
// lock sessions that give one requester exclusive use until its UNLOCK returns.

package falafel_lsu_arbiter_pkg;

    typedef enum logic [2:0] {
        LSU_OP_LOAD                    = 3'd0,
        LSU_OP_STORE                   = 3'd1,
        LSU_OP_LOCK                    = 3'd2,
        LSU_OP_UNLOCK                  = 3'd3,
        LSU_OP_EDIT_SIZE_AND_NEXT_ADDR = 3'd4
    } lsu_op_e;

    typedef struct packed {
        logic        val;
        lsu_op_e     lsu_op;
        logic [31:0] addr;
        logic [15:0] size;
    } header_req_t;

    typedef struct packed {
        logic        val;
        logic [31:0] addr;
        logic [15:0] size;
    } header_rsp_t;

endpackage

// state    | meaning
// IDLE     | grant one request (only the owner while a lock session is open)
// ISSUE    | drive the registered request to the LSU until it is accepted
// WAIT_RSP | wait for the LSU response and route it to the owner
module falafel_lsu_arbiter
    import falafel_lsu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  header_req_t [N_REQ-1:0]       req_i,
    output logic        [N_REQ-1:0]       req_rdy_o,
    output header_rsp_t [N_REQ-1:0]       rsp_o,
    output header_req_t                   lsu_req_o,
    input  logic                          lsu_req_rdy_i,
    input  header_rsp_t                   lsu_rsp_i,
    output logic        [IDX_W-1:0]       owner_o,
    output logic                          locked_o,
    output logic                          busy_o,
    output logic                          err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e             state_q;
    header_req_t        req_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   rr_q;
    logic               locked_q;
    logic               err_q;

    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic               rsp_fwd;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == N_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = rr_q;
        for (int n = 0; n < N_REQ; n++) begin
            if (!win_vld && req_i[scan_idx].val) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
            scan_idx = inc_idx(scan_idx);
        end
    end

    // While locked, only the owner may be granted; the rr winner is ignored.
    always_comb begin
        req_rdy_o = '0;
        grant_vld = 1'b0;
        grant_idx = win_idx;
        if (state_q == IDLE && !rst_i) begin
            if (locked_q) begin
                if (req_i[owner_q].val) begin
                    grant_vld = 1'b1;
                    grant_idx = owner_q;
                end
            end else if (win_vld) begin
                grant_vld = 1'b1;
                grant_idx = win_idx;
            end
            if (grant_vld) begin
                req_rdy_o[grant_idx] = 1'b1;
            end
        end
    end

    assign rsp_fwd = (state_q == WAIT_RSP) && lsu_rsp_i.val && !rst_i;

    always_comb begin
        rsp_o = '0;
        if (rsp_fwd) begin
            rsp_o[owner_q] = lsu_rsp_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            req_q    <= '0;
            owner_q  <= '0;
            rr_q     <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        req_q   <= req_i[grant_idx];
                        owner_q <= grant_idx;
                        state_q <= ISSUE;
                        if ((req_i[grant_idx].lsu_op == LSU_OP_LOCK && locked_q) ||
                            (req_i[grant_idx].lsu_op == LSU_OP_UNLOCK && !locked_q)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (lsu_req_rdy_i) begin
                        req_q.val <= 1'b0;
                        state_q   <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (lsu_rsp_i.val) begin
                        state_q <= IDLE;
                        if (req_q.lsu_op == LSU_OP_LOCK) begin
                            locked_q <= 1'b1;
                        end else if (req_q.lsu_op == LSU_OP_UNLOCK) begin
                            locked_q <= 1'b0;
                            rr_q     <= inc_idx(owner_q);
                        end else if (!locked_q) begin
                            rr_q <= inc_idx(owner_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A response with nothing outstanding is dropped and flagged.
            if (lsu_rsp_i.val && state_q != WAIT_RSP) begin
                err_q <= 1'b1;
            end
        end
    end

    assign lsu_req_o = req_q;
    assign owner_o   = owner_q;
    assign locked_o  = locked_q;
    assign busy_o    = (state_q != IDLE) || locked_q;
    assign err_o     = err_q;

endmodule
